// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// HALT_DETECT_EN (optional macro) enables the HALTED state in instr_fetch_unit.
package ifu_pkg;

   localparam int unsigned IFU_ADDR_W = 8;
   localparam int unsigned IFU_DATA_W = 8;
   localparam logic [7:0]  IFU_HALT_OPCODE = 8'hFF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      RESP   = 3'd2,
      HOLD   = 3'd3,
      HALTED = 3'd4
   } ifu_state_e;

endpackage

// File: rtl/ifu_pc.sv
// Program counter for the fetch unit: async reset, jump load, wrapping increment.
module ifu_pc
   import ifu_pkg::*;
#(
   parameter int unsigned          ADDR_W   = IFU_ADDR_W,
   parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_r;

   // PC update: load beats increment; the add wraps modulo 2^ADDR_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else if (load) begin
         pc_r <= load_addr;
      end else if (inc) begin
         pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         pc_r <= pc_r;
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: drives the 1-cycle instruction RAM and hands bytes to the decoder.
// Optional macro HALT_DETECT_EN: consuming HALT_OPCODE parks the unit in HALTED until a jump.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned       ADDR_W      = IFU_ADDR_W,
   parameter int unsigned       DATA_W      = IFU_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
   parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(IFU_HALT_OPCODE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] iAddr,
   output logic              FETCH,
   input  logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] instr_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted
);

`ifdef HALT_DETECT_EN
   localparam logic HALT_EN = 1'b1;
`else
   localparam logic HALT_EN = 1'b0;
`endif

   ifu_state_e        state_r, state_next_s;
   logic [DATA_W-1:0] instr_out_r, instr_out_next_s;
   logic              valid_r, valid_next_s;
   logic              halted_r, halted_next_s;
   logic              fetch_r;
   logic              pc_load_s, pc_inc_s;
   logic [ADDR_W-1:0] pc_s;

   ifu_pc #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (pc_load_s),
      .load_addr (jump_addr),
      .inc       (pc_inc_s),
      .pc        (pc_s)
   );

   // Next-state logic; a jump overrides everything, including a pending handshake.
   always_comb begin
      state_next_s     = state_r;
      instr_out_next_s = instr_out_r;
      valid_next_s     = valid_r;
      halted_next_s    = halted_r;
      pc_load_s        = 1'b0;
      pc_inc_s         = 1'b0;
      if (jump_en) begin
         pc_load_s     = 1'b1;
         valid_next_s  = 1'b0;
         halted_next_s = 1'b0;
         state_next_s  = run ? REQ : IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (run) begin
                  state_next_s = REQ;
               end else begin
                  state_next_s = IDLE;
               end
            end
            REQ: begin
               state_next_s = RESP;
            end
            RESP: begin
               instr_out_next_s = instr;
               valid_next_s     = 1'b1;
               state_next_s     = HOLD;
            end
            HOLD: begin
               if (instr_ready) begin
                  valid_next_s = 1'b0;
                  if (HALT_EN && (instr_out_r == HALT_OPCODE)) begin
                     halted_next_s = 1'b1;
                     state_next_s  = HALTED;
                  end else begin
                     pc_inc_s     = 1'b1;
                     state_next_s = run ? REQ : IDLE;
                  end
               end else begin
                  state_next_s = HOLD;
               end
            end
            HALTED: begin
               state_next_s = HALTED;
            end
            default: begin
               valid_next_s = 1'b0;
               state_next_s = IDLE;
            end
         endcase
      end
   end

   // State, capture register and registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         instr_out_r <= {DATA_W{1'b0}};
         valid_r     <= 1'b0;
         halted_r    <= 1'b0;
         fetch_r     <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         instr_out_r <= instr_out_next_s;
         valid_r     <= valid_next_s;
         halted_r    <= halted_next_s;
         fetch_r     <= (state_next_s == REQ);
      end
   end

   assign iAddr       = pc_s;
   assign pc_out      = pc_s;
   assign FETCH       = fetch_r;
   assign instr_out   = instr_out_r;
   assign instr_valid = valid_r;
   assign halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a 1-cycle synchronous RAM model.
module tb_instr_fetch_unit;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic       jump_en;
   logic [7:0] jump_addr;
   logic [7:0] iAddr;
   logic       FETCH;
   logic [7:0] instr;
   logic [7:0] instr_out;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] pc_out;
   logic       halted;

   logic [7:0] mem [256];
   int         total_cnt = 0;
   int         pass_cnt  = 0;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .iAddr       (iAddr),
      .FETCH       (FETCH),
      .instr       (instr),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc_out      (pc_out),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (FETCH) instr <= mem[iAddr];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic f, input logic [7:0] a,
                            input logic v, input logic [7:0] io, input logic [7:0] pc,
                            input logic h);
      check_eq({tag, ".fetch"}, {31'd0, FETCH}, {31'd0, f});
      check_eq({tag, ".iaddr"}, {24'd0, iAddr}, {24'd0, a});
      check_eq({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
      if (v) check_eq({tag, ".instr"}, {24'd0, instr_out}, {24'd0, io});
      check_eq({tag, ".pc"}, {24'd0, pc_out}, {24'd0, pc});
      check_eq({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[0]    = 8'h11;
      mem[1]    = 8'h22;
      mem[2]    = 8'h33;
      mem[3]    = 8'hFF;
      mem[8'h40] = 8'hA5;
      mem[8'hFF] = 8'hC3;
      instr       = 8'h00;
      rst_n       = 1'b0;
      run         = 1'b0;
      jump_en     = 1'b0;
      jump_addr   = 8'h00;
      instr_ready = 1'b0;

      #12;
      check_out("reset", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      check_eq("reset.instr_out", {24'd0, instr_out}, 32'h0);
      rst_n = 1'b1;
      tick();
      check_out("idle", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      // Basic stream at 3-cycle spacing.
      run = 1'b1;
      instr_ready = 1'b1;
      tick(); check_out("req0",  1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      tick(); check_out("resp0", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      tick(); check_out("hold0", 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0);
      tick(); check_out("req1",  1'b1, 8'h01, 1'b0, 8'h00, 8'h01, 1'b0);
      tick(); check_out("resp1", 1'b0, 8'h01, 1'b0, 8'h00, 8'h01, 1'b0);
      tick(); check_out("hold1", 1'b0, 8'h01, 1'b1, 8'h22, 8'h01, 1'b0);

      // Backpressure holds everything still.
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); check_out("bp", 1'b0, 8'h01, 1'b1, 8'h22, 8'h01, 1'b0);
      end
      instr_ready = 1'b1;
      tick(); check_out("bp_rel", 1'b1, 8'h02, 1'b0, 8'h00, 8'h02, 1'b0);

      // Jump while the response for address 2 is in flight.
      tick(); check_out("resp2", 1'b0, 8'h02, 1'b0, 8'h00, 8'h02, 1'b0);
      jump_en = 1'b1; jump_addr = 8'h40;
      tick(); jump_en = 1'b0;
      check_out("jresp", 1'b1, 8'h40, 1'b0, 8'h00, 8'h40, 1'b0);
      tick(); check_out("resp40", 1'b0, 8'h40, 1'b0, 8'h00, 8'h40, 1'b0);
      tick(); check_out("hold40", 1'b0, 8'h40, 1'b1, 8'hA5, 8'h40, 1'b0);

      // Jump together with ready: held byte dropped, no increment.
      jump_en = 1'b1; jump_addr = 8'hFF;
      tick(); jump_en = 1'b0;
      check_out("jhold", 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0);
      tick();
      tick(); check_out("holdff", 1'b0, 8'hFF, 1'b1, 8'hC3, 8'hFF, 1'b0);
      tick(); check_out("wrap", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      // run drop mid-transaction completes, then idles at pc+1.
      tick(); run = 1'b0;
      tick(); check_out("hold_nr", 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0);
      tick(); check_out("idle_nr", 1'b0, 8'h01, 1'b0, 8'h00, 8'h01, 1'b0);
      tick(); check_out("idle_nr2", 1'b0, 8'h01, 1'b0, 8'h00, 8'h01, 1'b0);
      run = 1'b1;
      tick(); check_out("resume", 1'b1, 8'h01, 1'b0, 8'h00, 8'h01, 1'b0);

      // Halt opcode at address 3.
      jump_en = 1'b1; jump_addr = 8'h03;
      tick(); jump_en = 1'b0;
      check_out("req3", 1'b1, 8'h03, 1'b0, 8'h00, 8'h03, 1'b0);
      tick();
      tick(); check_out("hold3", 1'b0, 8'h03, 1'b1, 8'hFF, 8'h03, 1'b0);
      tick();
`ifdef HALT_DETECT_EN
      check_out("halt", 1'b0, 8'h03, 1'b0, 8'h00, 8'h03, 1'b1);
      tick(); check_out("halt2", 1'b0, 8'h03, 1'b0, 8'h00, 8'h03, 1'b1);
      tick(); check_out("halt3", 1'b0, 8'h03, 1'b0, 8'h00, 8'h03, 1'b1);
`else
      check_out("nohalt", 1'b1, 8'h04, 1'b0, 8'h00, 8'h04, 1'b0);
`endif
      jump_en = 1'b1; jump_addr = 8'h00;
      tick(); jump_en = 1'b0;
      check_out("unhalt", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      // Async reset in HOLD.
      tick();
      tick(); check_out("hold_rst", 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0);
      instr_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_out("mid_rst", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      check_eq("mid_rst.instr_out", {24'd0, instr_out}, 32'h0);
      #2 rst_n = 1'b1;
      tick(); check_out("post_rst", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the instruction memory.
- Owns the program counter and drives iAddr/FETCH into the 1-cycle-latency synchronous instruction RAM.
- Captures the returned byte and presents it to the decoder with a valid/ready handshake.
- Supports run/stop, jumps, and optional halt-opcode detection.

Parameters:
- ADDR_W, 8, width of the program counter and iAddr.
- DATA_W, 8, instruction width.
- RESET_PC, 0, PC value after reset.
- HALT_OPCODE, 8'hFF, opcode that stops fetching (HALT_DETECT_EN only).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; enables fetching.
- jump_en  in  1  one-cycle pulse; load PC from jump_addr.
- jump_addr  in  ADDR_W  jump target.
- iAddr  out  ADDR_W  instruction memory address.
- FETCH  out  1  instruction memory read strobe.
- instr  in  DATA_W  memory data; valid the cycle after FETCH=1.
- instr_out  out  DATA_W  held instruction to the decoder.
- instr_valid  out  1  instr_out is valid.
- instr_ready  in  1  decoder accepts instr_out.
- pc_out  out  ADDR_W  address of the instruction in instr_out / in flight.
- halted  out  1  halt opcode consumed; fetching stopped.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, iAddr=RESET_PC, FETCH=0.
  - instr_out=0, instr_valid=0, halted=0.
  - Applies mid-operation; any in-flight response is discarded.
- States: IDLE, REQ, RESP, HOLD, HALTED (HALTED only with HALT_DETECT_EN).
- Transitions:
  - IDLE: FETCH=0. If run=1, go to REQ.
  - REQ: FETCH=1 and iAddr=pc for exactly one cycle; go to RESP.
  - RESP: FETCH=0. At the edge, instr_out<=instr, instr_valid<=1; go to HOLD.
  - HOLD: instr_valid=1, instr_out stable until accepted. On instr_ready=1:
    - pc<=pc+1, instr_valid<=0.
    - Next state is REQ if run=1, else IDLE.
    - With HALT_DETECT_EN and instr_out==HALT_OPCODE: go to HALTED instead, pc not incremented.
- Latency: FETCH to instr_valid is 2 cycles. Maximum throughput is one instruction per 3 cycles with instr_ready held high.
- run deassert:
  - Never aborts REQ/RESP/HOLD; the current instruction completes its handshake, then the block goes to IDLE.
  - PC is retained; reasserting run resumes at pc.
- jump_en (any state except reset):
  - pc<=jump_addr, instr_valid<=0, halted<=0.
  - Next state REQ if run=1, else IDLE.
  - A response pending in RESP is discarded.
  - Has priority over a simultaneous instr_ready (the held instruction is dropped, not consumed).
- PC arithmetic: modulo 2^ADDR_W; 8'hFF+1 wraps to 8'h00 silently.
- iAddr is registered and equals pc at all times. pc_out=pc.
- instr_ready while instr_valid=0 is ignored.

Optional Feature:
- Macro: HALT_DETECT_EN.
- Defined: consuming HALT_OPCODE moves the block to HALTED. In HALTED, halted=1 and FETCH=0, ignoring run. The only exits are jump_en and reset.
- Undefined: no HALTED state, halted tied 0, HALT_OPCODE is passed through like any other byte.

Decomposition:
- Package ifu_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, REQ, RESP, HOLD, HALTED), default HALT_OPCODE constant.
- One natural sub-module, ifu_pc: PC register with async reset, load (jump), increment enable, and wrap.
- The FSM and capture register stay in instr_fetch_unit.

Test Plan:
- Reset then run=1, ready=1, memory [0]=8'h11, [1]=8'h22 → FETCH pulses at iAddr 0 then 1; instr_out 8'h11 then 8'h22; valid 2 cycles after each FETCH; 3-cycle spacing.
- Backpressure: ready=0 for 5 cycles in HOLD → instr_out/instr_valid stable, no FETCH, pc unchanged; ready=1 → pc increments, next FETCH the following cycle.
- Jump during RESP with jump_addr=8'h40 → stale byte never appears valid; next FETCH at iAddr 8'h40.
- Jump same cycle as ready in HOLD → held instruction dropped, pc=jump_addr, no increment.
- PC wrap: jump to 8'hFF, consume → next FETCH at 8'h00.
- HALT_DETECT_EN, memory [3]=8'hFF → after consuming, halted=1 and no FETCH despite run=1; jump_en to 0 clears halted and fetches from 0. Also: rst_n low mid-HOLD → all outputs at reset values immediately.
